// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin/change encodings, coin values and FSM states shared by vend_ctrl
package vend_pkg;

    typedef enum logic [2:0] {
        COIN_NICKEL  = 3'd0,
        COIN_DIME    = 3'd1,
        COIN_QUARTER = 3'd2,
        COIN_FIFTY   = 3'd3,
        COIN_DOLLAR  = 3'd4,
        COIN_FIVE    = 3'd5
    } coin_type_e;

    typedef enum logic [1:0] {
        CHG_NICKEL  = 2'd0,
        CHG_DIME    = 2'd1,
        CHG_QUARTER = 2'd2,
        CHG_DOLLAR  = 2'd3
    } chg_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } vend_state_e;

    localparam int VAL_NICKEL  = 5;
    localparam int VAL_DIME    = 10;
    localparam int VAL_QUARTER = 25;
    localparam int VAL_FIFTY   = 50;
    localparam int VAL_DOLLAR  = 100;
    localparam int VAL_FIVE    = 500;

    // Zero marks an unrecognised coin type.
    function automatic int coin_value(input logic [2:0] t);
        case (t)
            COIN_NICKEL:  return VAL_NICKEL;
            COIN_DIME:    return VAL_DIME;
            COIN_QUARTER: return VAL_QUARTER;
            COIN_FIFTY:   return VAL_FIFTY;
            COIN_DOLLAR:  return VAL_DOLLAR;
            COIN_FIVE:    return VAL_FIVE;
            default:      return 0;
        endcase
    endfunction

    function automatic int chg_value(input logic [1:0] t);
        case (t)
            CHG_NICKEL:  return VAL_NICKEL;
            CHG_DIME:    return VAL_DIME;
            CHG_QUARTER: return VAL_QUARTER;
            default:     return VAL_DOLLAR;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// rtl/vend_change_gen.sv - greedy choice of the next change coin for the remaining amount
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CENTS_W = 10
) (
    input  logic [CENTS_W-1:0] remaining,
    output logic [1:0]         chg_type
);

    always_comb begin
        chg_type = CHG_NICKEL;
        if (remaining >= CENTS_W'(VAL_DOLLAR)) begin
            chg_type = CHG_DOLLAR;
        end else if (remaining >= CENTS_W'(VAL_QUARTER)) begin
            chg_type = CHG_QUARTER;
        end else if (remaining >= CENTS_W'(VAL_DIME)) begin
            chg_type = CHG_DIME;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending machine controller: credit, prices, vend and change dispensing
// Optional feature macro: VEND_PRICE_PEEK_EN (zero-credit selection shows the slot price)
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int  NUM_SLOTS  = 9,
    parameter int  CENTS_W    = 10,
    parameter int  MAX_CREDIT = 500,
    localparam int IW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coin_valid,
    input  logic [2:0]           coin_type,
    input  logic                 sel_valid,
    input  logic [IW-1:0]        sel_idx,
    input  logic                 cancel,
    input  logic                 cfg_we,
    input  logic [IW-1:0]        cfg_idx,
    input  logic [CENTS_W-1:0]   cfg_price,
    output logic [CENTS_W-1:0]   credit,
    output logic [CENTS_W-1:0]   disp_val,
    output logic [NUM_SLOTS-1:0] avail,
    output logic [NUM_SLOTS-1:0] oos,
    output logic                 vend_valid,
    output logic [IW-1:0]        vend_idx,
    output logic                 coin_reject,
    output logic                 sel_nak,
    output logic                 chg_valid,
    output logic [1:0]           chg_type,
    input  logic                 chg_ready,
    output logic                 busy
);

    vend_state_e        state_q, state_d;
    logic [CENTS_W-1:0] credit_q, credit_d;
    logic [CENTS_W-1:0] change_q, change_d;
    logic [IW-1:0]      vend_idx_q, vend_idx_d;
    logic               coin_reject_q, coin_reject_d;
    logic               sel_nak_q, sel_nak_d;
    logic               peek_valid_q, peek_valid_d;
    logic [CENTS_W-1:0] peek_val_q, peek_val_d;
    logic [CENTS_W-1:0] price_q [NUM_SLOTS];
    logic [CENTS_W-1:0] price_d [NUM_SLOTS];

    logic               sel_in_range;
    logic [CENTS_W-1:0] sel_price;
    logic [CENTS_W:0]   coin_sum;
    logic               coin_ok;

    function automatic logic [CENTS_W-1:0] round5(input logic [CENTS_W-1:0] v);
        return v - (v % CENTS_W'(5));
    endfunction

    vend_change_gen #(.CENTS_W(CENTS_W)) u_change_gen (
        .remaining (change_q),
        .chg_type  (chg_type)
    );

    assign sel_in_range = {1'b0, sel_idx} < (IW+1)'(NUM_SLOTS);
    assign sel_price    = sel_in_range ? price_q[sel_idx] : '0;
    assign coin_sum     = {1'b0, credit_q} + (CENTS_W+1)'(coin_value(coin_type));
    assign coin_ok      = (coin_value(coin_type) != 0) && (coin_sum <= (CENTS_W+1)'(MAX_CREDIT));

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            price_d[i] = (cfg_we && ({1'b0, cfg_idx} == (IW+1)'(i))) ? cfg_price : price_q[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_d      = change_q;
        vend_idx_d    = vend_idx_q;
        coin_reject_d = coin_valid;
        sel_nak_d     = 1'b0;
        peek_valid_d  = peek_valid_q;
        peek_val_d    = peek_val_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cancel || sel_valid || coin_valid) begin
                    peek_valid_d = 1'b0;
                end
                if (cancel) begin
                    if (credit_q != '0) begin
                        change_d = round5(credit_q);
                        credit_d = '0;
                        state_d  = ST_CHANGE;
                    end
                end else if (sel_valid) begin
                    if (sel_price == '0) begin
                        sel_nak_d = 1'b1;
                    end else if (credit_q == '0) begin
`ifdef VEND_PRICE_PEEK_EN
                        peek_valid_d = 1'b1;
                        peek_val_d   = sel_price;
`else
                        sel_nak_d = 1'b1;
`endif
                    end else if (credit_q < sel_price) begin
                        sel_nak_d = 1'b1;
                    end else begin
                        change_d   = credit_q - sel_price;
                        credit_d   = '0;
                        vend_idx_d = sel_idx;
                        state_d    = ST_VEND;
                    end
                end else if (coin_valid) begin
                    coin_reject_d = !coin_ok;
                    if (coin_ok) begin
                        credit_d = coin_sum[CENTS_W-1:0];
                    end
                end
            end
            ST_VEND: begin
                // Odd-cent remainders from non-multiple-of-5 prices are forfeited here.
                change_d = round5(change_q);
                state_d  = (change_q == '0) ? ST_IDLE : ST_CHANGE;
            end
            ST_CHANGE: begin
                if (change_q == '0) begin
                    state_d = ST_IDLE;
                end else if (chg_ready) begin
                    change_d = change_q - CENTS_W'(chg_value(chg_type));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            change_q      <= '0;
            vend_idx_q    <= '0;
            coin_reject_q <= 1'b0;
            sel_nak_q     <= 1'b0;
            peek_valid_q  <= 1'b0;
            peek_val_q    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                price_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            change_q      <= change_d;
            vend_idx_q    <= vend_idx_d;
            coin_reject_q <= coin_reject_d;
            sel_nak_q     <= sel_nak_d;
            peek_valid_q  <= peek_valid_d;
            peek_val_q    <= peek_val_d;
            price_q       <= price_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            oos[i]   = (price_q[i] == '0);
            avail[i] = (price_q[i] != '0) && (credit_q >= price_q[i]);
        end
    end

    always_comb begin
        disp_val = peek_valid_q ? peek_val_q : credit_q;
        if (state_q == ST_VEND) begin
            disp_val = price_q[vend_idx_q];
        end else if (state_q == ST_CHANGE) begin
            disp_val = change_q;
        end
    end

    assign credit      = credit_q;
    assign vend_valid  = (state_q == ST_VEND);
    assign vend_idx    = vend_idx_q;
    assign coin_reject = coin_reject_q;
    assign sel_nak     = sel_nak_q;
    assign chg_valid   = (state_q == ST_CHANGE) && (change_q != '0);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - self-checking bench for vend_ctrl: vector table, corner sequences, random vs reference model
module tb_vend_ctrl;

    localparam int NUM_SLOTS  = 9;
    localparam int CENTS_W    = 10;
    localparam int MAX_CREDIT = 500;
    localparam int IW         = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 coin_valid = 1'b0;
    logic [2:0]           coin_type = '0;
    logic                 sel_valid = 1'b0;
    logic [IW-1:0]        sel_idx = '0;
    logic                 cancel = 1'b0;
    logic                 cfg_we = 1'b0;
    logic [IW-1:0]        cfg_idx = '0;
    logic [CENTS_W-1:0]   cfg_price = '0;
    logic [CENTS_W-1:0]   credit, disp_val;
    logic [NUM_SLOTS-1:0] avail, oos;
    logic                 vend_valid, coin_reject, sel_nak, chg_valid, busy;
    logic [IW-1:0]        vend_idx;
    logic [1:0]           chg_type;
    logic                 chg_ready = 1'b1;

    vend_ctrl #(.NUM_SLOTS(NUM_SLOTS), .CENTS_W(CENTS_W), .MAX_CREDIT(MAX_CREDIT)) dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_price(cfg_price), .credit(credit), .disp_val(disp_val),
        .avail(avail), .oos(oos), .vend_valid(vend_valid), .vend_idx(vend_idx),
        .coin_reject(coin_reject), .sel_nak(sel_nak), .chg_valid(chg_valid),
        .chg_type(chg_type), .chg_ready(chg_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 vend, 2 paying change; change kept as a queue of coins.
    int m_mode, m_credit, m_pending, m_vidx, m_peek_val;
    bit m_rej, m_nak, m_peek;
    int m_prices[NUM_SLOTS];
    int m_coins[$];
    int got[$];

    function automatic int coin_cents(input int t);
        case (t)
            0: return 5;   1: return 10;  2: return 25;
            3: return 50;  4: return 100; 5: return 500;
            default: return 0;
        endcase
    endfunction

    function automatic int chg_cents(input int t);
        case (t)
            0: return 5; 1: return 10; 2: return 25; default: return 100;
        endcase
    endfunction

    function automatic void load_change(input int amount);
        int r = amount - (amount % 5);
        m_coins.delete();
        while (r > 0) begin
            if (r >= 100)     begin m_coins.push_back(3); r -= 100; end
            else if (r >= 25) begin m_coins.push_back(2); r -= 25;  end
            else if (r >= 10) begin m_coins.push_back(1); r -= 10;  end
            else              begin m_coins.push_back(0); r -= 5;   end
        end
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_credit = 0; m_pending = 0; m_vidx = 0;
        m_rej = 0; m_nak = 0; m_peek = 0; m_peek_val = 0;
        m_coins.delete();
        for (int i = 0; i < NUM_SLOTS; i++) m_prices[i] = 0;
    endfunction

    function automatic void model_step();
        int p = 0, v, new_idx = -1, new_p = 0;
        m_rej = 0; m_nak = 0;
        if (cfg_we && cfg_idx < NUM_SLOTS) begin new_idx = cfg_idx; new_p = cfg_price; end
        if (m_mode == 0) begin
            if (cancel || sel_valid || coin_valid) m_peek = 0;
            if (cancel) begin
                m_rej = coin_valid;
                if (m_credit > 0) begin load_change(m_credit); m_credit = 0; m_mode = 2; end
            end else if (sel_valid) begin
                m_rej = coin_valid;
                if (sel_idx < NUM_SLOTS) p = m_prices[sel_idx];
                if (p == 0) m_nak = 1;
                else if (m_credit == 0) begin
`ifdef VEND_PRICE_PEEK_EN
                    m_peek = 1; m_peek_val = p;
`else
                    m_nak = 1;
`endif
                end else if (m_credit < p) m_nak = 1;
                else begin m_pending = m_credit - p; m_credit = 0; m_vidx = sel_idx; m_mode = 1; end
            end else if (coin_valid) begin
                v = coin_cents(coin_type);
                if (v > 0 && m_credit + v <= MAX_CREDIT) m_credit += v;
                else m_rej = 1;
            end
        end else if (m_mode == 1) begin
            m_rej = coin_valid;
            if (m_pending == 0) m_mode = 0;
            else begin load_change(m_pending); m_mode = 2; end
        end else begin
            m_rej = coin_valid;
            if (m_coins.size() == 0) m_mode = 0;
            else if (chg_ready) void'(m_coins.pop_front());
        end
        if (new_idx >= 0) m_prices[new_idx] = new_p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int e_disp = 0, e_av = 0, e_oos = 0;
        if (m_mode == 0) e_disp = m_peek ? m_peek_val : m_credit;
        else if (m_mode == 1) e_disp = m_prices[m_vidx];
        else foreach (m_coins[k]) e_disp += chg_cents(m_coins[k]);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m_prices[i] == 0) e_oos |= (1 << i);
            else if (m_credit >= m_prices[i]) e_av |= (1 << i);
        end
        chk("m_credit", 32'(credit), 32'(m_credit));
        chk("m_disp", 32'(disp_val), 32'(e_disp));
        chk("m_avail", 32'(avail), 32'(e_av));
        chk("m_oos", 32'(oos), 32'(e_oos));
        chk("m_busy", 32'(busy), 32'(m_mode != 0));
        chk("m_vend_valid", 32'(vend_valid), 32'(m_mode == 1));
        if (m_mode == 1) chk("m_vend_idx", 32'(vend_idx), 32'(m_vidx));
        chk("m_coin_reject", 32'(coin_reject), 32'(m_rej));
        chk("m_sel_nak", 32'(sel_nak), 32'(m_nak));
        chk("m_chg_valid", 32'(chg_valid), 32'(m_mode == 2 && m_coins.size() > 0));
        if (m_mode == 2 && m_coins.size() > 0) chk("m_chg_type", 32'(chg_type), 32'(m_coins[0]));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic clear_inputs();
        coin_valid = 0; sel_valid = 0; cancel = 0; cfg_we = 0;
    endtask

    task automatic one(input bit cv, input int ct, input bit sv, input int si, input bit cn);
        clear_inputs();
        coin_valid = cv; coin_type = 3'(ct); sel_valid = sv; sel_idx = IW'(si); cancel = cn;
        cycle();
        clear_inputs();
    endtask

    task automatic set_price(input int idx, input int p);
        clear_inputs();
        cfg_we = 1; cfg_idx = IW'(idx); cfg_price = CENTS_W'(p);
        cycle();
        clear_inputs();
    endtask

    task automatic drain();
        int guard = 0;
        got.delete();
        chg_ready = 1;
        clear_inputs();
        while (busy === 1'b1 && guard < 40) begin
            if (chg_valid === 1'b1) got.push_back(int'(chg_type));
            cycle();
            guard++;
        end
        chk("drain_done", 32'(busy), 32'(0));
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    typedef struct {
        bit cv; int ct; bit sv; int si; bit cn;
        int e_credit; bit e_rej; bit e_nak; bit e_vend; bit e_busy;
    } vec_t;
    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 4, 0, 0, 0, 100, 0, 0, 0, 0};
        tbl[1]  = '{1, 6, 0, 0, 0, 100, 1, 0, 0, 0};
        tbl[2]  = '{1, 5, 0, 0, 0, 100, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 2, 0, 100, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 1, 9, 0, 100, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 3, 0, 100, 0, 1, 0, 0};
        tbl[6]  = '{1, 2, 0, 0, 0, 125, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 1, 0, 0,   0, 1, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[11] = '{1, 7, 0, 0, 0,   0, 1, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        chk("rst_credit", 32'(credit), 0);
        chk("rst_oos", 32'(oos), 32'h1FF);
        rst_n = 1;

        set_price(0, 100); set_price(1, 65); set_price(3, 125);
        chg_ready = 1;
        for (int i = 0; i < 13; i++) begin
            one(tbl[i].cv, tbl[i].ct, tbl[i].sv, tbl[i].si, tbl[i].cn);
            chk($sformatf("tbl%0d_credit", i), 32'(credit), 32'(tbl[i].e_credit));
            chk($sformatf("tbl%0d_reject", i), 32'(coin_reject), 32'(tbl[i].e_rej));
            chk($sformatf("tbl%0d_nak", i), 32'(sel_nak), 32'(tbl[i].e_nak));
            chk($sformatf("tbl%0d_vend", i), 32'(vend_valid), 32'(tbl[i].e_vend));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end

        // Exact-price vend: no change, straight back to idle.
        one(1, 4, 0, 0, 0);
        one(0, 0, 1, 0, 0);
        chk("exact_vend", 32'(vend_valid), 1);
        chk("exact_vend_idx", 32'(vend_idx), 0);
        one(0, 0, 0, 0, 0);
        chk("exact_no_chg", 32'(chg_valid), 0);
        chk("exact_credit", 32'(credit), 0);
        chk("exact_idle", 32'(busy), 0);

        // 35 change with a stalled hopper.
        one(1, 4, 0, 0, 0);
        one(0, 0, 1, 1, 0);
        chk("c35_vend_idx", 32'(vend_idx), 1);
        chk("c35_disp_price", 32'(disp_val), 65);
        chg_ready = 0;
        one(0, 0, 0, 0, 0);
        chk("c35_disp", 32'(disp_val), 35);
        for (int i = 0; i < 4; i++) begin
            chk("c35_stall_valid", 32'(chg_valid), 1);
            chk("c35_stall_type", 32'(chg_type), 2);
            if (i < 3) one(0, 0, 0, 0, 0);
        end
        chg_ready = 1;
        one(0, 0, 0, 0, 0);
        chk("c35_dime", 32'(chg_type), 1);
        chk("c35_dime_valid", 32'(chg_valid), 1);
        one(0, 0, 0, 0, 0);
        chk("c35_done_valid", 32'(chg_valid), 0);
        chk("c35_done_busy", 32'(busy), 1);
        one(0, 0, 0, 0, 0);
        chk("c35_idle", 32'(busy), 0);

        // Credit ceiling.
        repeat (4) one(1, 4, 0, 0, 0);
        one(1, 3, 0, 0, 0);
        one(1, 4, 0, 0, 0);
        chk("cap_reject", 32'(coin_reject), 1);
        chk("cap_credit", 32'(credit), 450);
        one(1, 3, 0, 0, 0);
        chk("cap_fill", 32'(credit), 500);
        one(0, 0, 0, 0, 1);
        drain();
        chk("cap_refund_n", 32'(got.size()), 5);
        foreach (got[k]) chk("cap_refund_dollar", 32'(got[k]), 3);

        // Coin colliding with a winning selection, then refund of 40.
        one(1, 4, 0, 0, 0);
        one(1, 2, 1, 0, 0);
        chk("coll_vend", 32'(vend_valid), 1);
        chk("coll_reject", 32'(coin_reject), 1);
        one(0, 0, 0, 0, 0);
        one(1, 2, 0, 0, 0); one(1, 1, 0, 0, 0); one(1, 0, 0, 0, 0);
        chk("r40_credit", 32'(credit), 40);
        one(0, 0, 0, 0, 1);
        drain();
        chk("r40_n", 32'(got.size()), 3);
        if (got.size() == 3) begin
            chk("r40_q", 32'(got[0]), 2);
            chk("r40_d", 32'(got[1]), 1);
            chk("r40_n5", 32'(got[2]), 0);
        end

        // Out-of-stock selection, then reset in the middle of a refund.
        one(1, 4, 0, 0, 0);
        one(0, 0, 1, 2, 0);
        chk("oos_nak", 32'(sel_nak), 1);
        chk("oos_bit", 32'(oos[2]), 1);
        one(0, 0, 0, 0, 1);
        chk("rstchg_valid_pre", 32'(chg_valid), 1);
        rst_n = 0;
        #1;
        chk("rstchg_valid", 32'(chg_valid), 0);
        chk("rstchg_credit", 32'(credit), 0);
        chk("rstchg_busy", 32'(busy), 0);
        chk("rstchg_price", 32'(oos), 32'h1FF);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;

        // Zero-credit selection of an in-stock slot.
        set_price(3, 125);
        one(0, 0, 1, 3, 0);
`ifdef VEND_PRICE_PEEK_EN
        chk("peek_disp", 32'(disp_val), 125);
        chk("peek_nak", 32'(sel_nak), 0);
`else
        chk("peek_disp", 32'(disp_val), 0);
        chk("peek_nak", 32'(sel_nak), 1);
`endif
        one(1, 0, 0, 0, 0);
        chk("peek_clear", 32'(disp_val), 5);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < NUM_SLOTS; i++) set_price(i, (i % 3 == 0) ? 0 : 35 + 30 * i);
        for (int n = 0; n < 3000; n++) begin
            int r = int'($urandom_range(0, 99));
            clear_inputs();
            coin_valid = (r < 35);
            coin_type  = 3'($urandom_range(0, 7));
            sel_valid  = ($urandom_range(0, 99) < 18);
            sel_idx    = IW'($urandom_range(0, 10));
            cancel     = ($urandom_range(0, 99) < 4);
            cfg_we     = ($urandom_range(0, 99) < 3);
            cfg_idx    = IW'($urandom_range(0, 9));
            case ($urandom_range(0, 4))
                0: cfg_price = 0;
                1: cfg_price = 65;
                2: cfg_price = 98;
                3: cfg_price = 125;
                default: cfg_price = 100;
            endcase
            chg_ready  = ($urandom_range(0, 99) < 70);
            cycle();
        end
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
